// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier: one Booth iteration per clock, WIDTH+1 iterations
// on (WIDTH+1)-bit extended operands, so signed and unsigned products are both exact.
module booth_seq_mult #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned     CW    = $clog2(WIDTH + 2);
    localparam logic [CW-1:0]   ITERS = CW'(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH:0]       acc_q, acc_d;
    logic [WIDTH:0]       mq_q, mq_d;
    logic [WIDTH:0]       mcand_q, mcand_d;
    logic                 qm1_q, qm1_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH:0]       sum;
    logic [2*WIDTH+1:0]   shifted;

    always_comb begin
        unique case ({mq_q[0], qm1_q})
            2'b01:   sum = acc_q + mcand_q;
            2'b10:   sum = acc_q - mcand_q;
            default: sum = acc_q;
        endcase
        // Arithmetic right shift of the {acc, mq} pair; q(-1) picks up the old mq LSB.
        shifted = {sum[WIDTH], sum, mq_q[WIDTH:1]};
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        mcand_d   = mcand_q;
        qm1_d     = qm1_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    mcand_d = {signed_mode & multiplicand[WIDTH-1], multiplicand};
                    mq_d    = {signed_mode & multiplier[WIDTH-1], multiplier};
                    acc_d   = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = ITERS;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                acc_d = shifted[2*WIDTH+1:WIDTH+1];
                mq_d  = shifted[WIDTH:0];
                qm1_d = mq_q[0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    product_d = shifted[2*WIDTH-1:0];
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == CALC);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mq_q      <= '0;
            mcand_q   <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            mcand_q   <= mcand_d;
            qm1_q     <= qm1_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule
